// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin arbiter sharing one 2:1 select path between two
// requesters, with a bounded burst length and a valid/ready handshake downstream.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req0/data0          requester 0 request and data
//   req1/data1          requester 1 request and data
//   ready               downstream accepts this cycle
//   sel                 mux select, 0 = data0, 1 = data1 (registered)
//   gnt0/gnt1           requester owns the path (registered)
//   dout                sel ? data1 : data0 (combinational)
//   valid               owner is requesting (combinational)
//   ack0/ack1           transfer completes this cycle for that requester (combinational)
//   busy                arbiter not idle (registered)
module mux2_rr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             ready,
    output logic             sel,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             ack0,
    output logic             ack1,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             xfer;

    // Handshake decode from the registered grants.
    assign dout  = sel ? data1 : data0;
    assign valid = (gnt0 & req0) | (gnt1 & req1);
    assign ack0  = valid & ready & gnt0;
    assign ack1  = valid & ready & gnt1;
    assign xfer  = valid & ready;

    // State, beat counter, priority and registered output decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            sel     <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel     <= (state_d == GRANT1);
            gnt0    <= (state_d == GRANT0);
            gnt1    <= (state_d == GRANT1);
            busy    <= (state_d != IDLE);
        end
    end

    // Next-state: arbitration from idle, burst-bounded release while granted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                end else if (req0) begin
                    state_d = GRANT0;
                end else if (req1) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!req0 || (xfer && (cnt_q == LAST_BEAT) && req1)) begin
                    state_d = req1 ? GRANT1 : IDLE;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (xfer) begin
                    // Uncontested at the burst limit: wrap and keep the grant.
                    cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
                end
            end
            GRANT1: begin
                if (!req1 || (xfer && (cnt_q == LAST_BEAT) && req0)) begin
                    state_d = req0 ? GRANT0 : IDLE;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end else if (xfer) begin
                    cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
